// File: rtl/counter_pkg.sv
// Shared definitions for the loadable down-counter: state encoding and default width.
package counter_pkg;

  // Default counter/load width; must match the downstream zero detector input.
  localparam int unsigned CNT_WIDTH_DEFAULT = 8;

  // Counter control states. Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/down_counter8.sv
// Loadable down-counter feeding the zero detector: load, count enable,
// one-cycle terminal-count pulse, busy status and optional auto-reload.
module down_counter8
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_WIDTH_DEFAULT,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;

  // Next-state logic: load overrides everything, then per-state count/expiry/reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    if (load) begin
      cnt_d = load_val;
      rld_d = load_val;
      if (load_val != CNT_ZERO) begin
        state_d = ST_RUN;
      end else begin
        // A zero load expires immediately so it still produces one done pulse.
        state_d = ST_DONE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (en) begin
            if (cnt_q == CNT_ONE) begin
              cnt_d   = CNT_ZERO;
              state_d = ST_DONE;
            end else if (cnt_q == CNT_ZERO) begin
              // Unreachable in normal operation; never wrap below zero.
              cnt_d   = CNT_ZERO;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_DONE: begin
          if (AUTO_RELOAD && (rld_q != CNT_ZERO)) begin
            cnt_d   = rld_q;
            state_d = ST_RUN;
          end else begin
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
          end
        end
        default: begin
          // Illegal encoding: return to IDLE, leave the count untouched.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, count and reload registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      rld_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
    end
  end

  assign cnt_out = cnt_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_down_counter8.sv
// Self-checking bench: one counter without and one with auto-reload, driven by
// the same stimulus and checked every cycle against a behavioural model.
module tb_down_counter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       en = 1'b0;

  logic [7:0] cnt_a, cnt_b;
  logic       busy_a, busy_b, done_a, done_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: per instance the count, the reload value and a phase
  // (0 = stopped, 1 = counting, 2 = just expired).
  int m_cnt[2];
  int m_rld[2];
  int m_ph[2];

  always #5 clk = ~clk;

  down_counter8 #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .cnt_out(cnt_a), .busy(busy_a), .done(done_a)
  );

  down_counter8 #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .cnt_out(cnt_b), .busy(busy_b), .done(done_b)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Advance the behavioural model on each rising edge from the applied inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k] = 0; m_rld[k] = 0; m_ph[k] = 0;
      end else if (load) begin
        m_cnt[k] = int'(load_val);
        m_rld[k] = int'(load_val);
        m_ph[k]  = (load_val == 8'd0) ? 2 : 1;
      end else if (m_ph[k] == 1) begin
        if (en) begin
          m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
          if (m_cnt[k] == 0) m_ph[k] = 2;
        end
      end else if (m_ph[k] == 2) begin
        if (k == 1 && m_rld[k] != 0) begin
          m_cnt[k] = m_rld[k];
          m_ph[k]  = 1;
        end else begin
          m_cnt[k] = 0;
          m_ph[k]  = 0;
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a_cnt",  int'(cnt_a),  m_cnt[0]);
      cmp("a_busy", int'(busy_a), int'(m_ph[0] == 1));
      cmp("a_done", int'(done_a), int'(m_ph[0] == 2));
      cmp("b_cnt",  int'(cnt_b),  m_cnt[1]);
      cmp("b_busy", int'(busy_b), int'(m_ph[1] == 1));
      cmp("b_done", int'(done_b), int'(m_ph[1] == 2));
    end
  end

  // Apply one cycle of inputs at the falling edge and return at the next one.
  task automatic step(input bit r, input bit ld, input logic [7:0] lv, input bit e);
    rst = r; load = ld; load_val = lv; en = e;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 8'd0, 1'b0);
    chk_en = 1'b1;
    cmp("rst_cnt",  int'(cnt_a),  0);
    cmp("rst_busy", int'(busy_a), 0);
    cmp("rst_done", int'(done_a), 0);

    // Load 3 with en high: 3,2,1,0 then stop (a) / reload (b).
    step(1'b0, 1'b1, 8'h03, 1'b1);
    cmp("ld3_cnt",  int'(cnt_a),  3);
    cmp("ld3_busy", int'(busy_a), 1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("ld3_c2", int'(cnt_a), 2);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("ld3_c1", int'(cnt_a), 1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("ld3_c0",   int'(cnt_a),  0);
    cmp("ld3_done", int'(done_a), 1);
    cmp("ld3_nbsy", int'(busy_a), 0);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("idle_cnt",  int'(cnt_a),  0);
    cmp("idle_done", int'(done_a), 0);
    cmp("rld_cnt",   int'(cnt_b),  3);
    cmp("rld_busy",  int'(busy_b), 1);

    // Auto-reload of 2: 2,1,0,2,1,0 with done every third cycle.
    step(1'b0, 1'b1, 8'h02, 1'b1);
    cmp("ar_2a", int'(cnt_b), 2);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("ar_1a", int'(cnt_b), 1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("ar_0a", int'(cnt_b), 0);
    cmp("ar_da", int'(done_b), 1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("ar_2b", int'(cnt_b), 2);
    cmp("ar_db", int'(done_b), 0);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("ar_1b", int'(cnt_b), 1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("ar_0b", int'(cnt_b), 0);
    cmp("ar_dc", int'(done_b), 1);

    // Load 0: single done pulse, then a load of 4 during DONE.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    cmp("z_cnt",  int'(cnt_a),  0);
    cmp("z_done", int'(done_a), 1);
    cmp("z_busy", int'(busy_a), 0);
    step(1'b0, 1'b1, 8'h04, 1'b0);
    cmp("l4_cnt",  int'(cnt_a),  4);
    cmp("l4_busy", int'(busy_a), 1);
    cmp("l4_done", int'(done_a), 0);

    // Load 5 with a two-cycle en gap: expiry arrives two cycles late.
    step(1'b0, 1'b1, 8'h05, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    cmp("gap_hold", int'(cnt_a), 4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("gap_c1",  int'(cnt_a),  1);
    cmp("gap_bsy", int'(busy_a), 1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("gap_c0",   int'(cnt_a),  0);
    cmp("gap_done", int'(done_a), 1);

    // Load 0xFF, ten decrements, then reset mid-run.
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'd0, 1'b1);
    cmp("ff_c245", int'(cnt_a), 245);
    step(1'b1, 1'b0, 8'd0, 1'b1);
    cmp("ff_rcnt",  int'(cnt_a),  0);
    cmp("ff_rbusy", int'(busy_a), 0);
    cmp("ff_rdone", int'(done_a), 0);
    cmp("ff_rcntb", int'(cnt_b),  0);

    // Randomized traffic checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, e;
      logic [7:0] lv;
      r  = ($urandom_range(99) < 2);
      ld = ($urandom_range(99) < 10);
      e  = ($urandom_range(99) < 70);
      lv = ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(6));
      step(r, ld, lv, e);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
